rel_phase_mask_pack: RTL and testbench

- Downstream stage of the 4-step relative-phase calculator.
- Consumes its per-pixel stream (vld, signed phase, modulation rate, tlast).
- Replaces low-modulation pixels with an invalid code, then packs two phase samples per 32-bit AXI4-Stream beat with line/frame markers.
- Buffers beats in a FIFO, because the upstream stream has no backpressure while the downstream DMA does.

---
 rtl/rel_phase_mask_pack.sv | 178 +++++++++++++++++
 tb/tb_rel_phase_mask_pack.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rel_phase_mask_pack.sv
// Masks low-modulation phase pixels, packs two samples per AXI4-Stream beat with
// line/frame markers, and buffers beats in an FWFT FIFO. Optional: REL_PHASE_OFFSET_EN.
module rel_phase_mask_pack #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    FIFO_DEPTH   = 64,
  parameter int                    FRAME_LINES  = 1024,
  parameter logic [DATA_WIDTH-1:0] INVALID_CODE = 16'h8000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vld_i,
  input  logic [DATA_WIDTH-1:0]         phase_i,
  input  logic [DATA_WIDTH-1:0]         mod_i,
  input  logic                          tlast_i,
  input  logic [DATA_WIDTH-1:0]         mod_thresh_i,
  input  logic                          clr_ovf_i,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [2*DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [2*DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fill_o
);

  localparam int BW = 2 * DATA_WIDTH;
  localparam int KW = BW / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int EW = BW + KW + 2;
  localparam logic [KW-1:0] KEEP_LO = {{(KW - KW / 2){1'b0}}, {(KW / 2){1'b1}}};

  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} pack_state_t;

  // ---------------- mask stage ----------------
  logic                  mask_pass;
  logic [DATA_WIDTH-1:0] mask_sample;
  logic                  s_vld;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

`ifdef REL_PHASE_OFFSET_EN
  localparam logic [DATA_WIDTH-1:0] PI_OFFSET = DATA_WIDTH'(25736);
  always_comb begin
    mask_pass   = (mod_i >= mod_thresh_i);
    mask_sample = mask_pass ? (phase_i + PI_OFFSET) : INVALID_CODE;
  end
`else
  always_comb begin
    mask_pass   = (mod_i >= mod_thresh_i);
    mask_sample = mask_pass ? phase_i : INVALID_CODE;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) s_vld <= 1'b0;
    else        s_vld <= vld_i;
  end

  always_ff @(posedge clk) begin
    s_data <= mask_sample;
    s_last <= tlast_i;
  end

  // ---------------- packer FSM ----------------
  pack_state_t           pack_state, pack_state_nxt;
  logic [DATA_WIDTH-1:0] low_q;
  logic [LW-1:0]         line_cnt;
  logic                  first_of_line;
  logic                  beat_wr;
  logic [BW-1:0]         beat_data;
  logic [KW-1:0]         beat_keep;
  logic                  beat_last;
  logic                  beat_user;

  always_comb begin
    pack_state_nxt = pack_state;
    beat_wr        = 1'b0;
    beat_data      = {s_data, low_q};
    beat_keep      = '1;
    beat_last      = s_last;
    beat_user      = first_of_line && (line_cnt == '0);
    if (s_vld) begin
      case (pack_state)
        EMPTY: begin
          if (s_last) begin
            beat_wr   = 1'b1;
            beat_data = {{DATA_WIDTH{1'b0}}, s_data};
            beat_keep = KEEP_LO;
          end else begin
            pack_state_nxt = HALF;
          end
        end
        HALF: begin
          beat_wr        = 1'b1;
          pack_state_nxt = EMPTY;
        end
        default: pack_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pack_state <= EMPTY;
    else        pack_state <= pack_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (s_vld && (pack_state == EMPTY) && !s_last) low_q <= s_data;
  end

  // Markers advance on every completed beat, even one the FIFO later drops.
  logic          b_vld;
  logic [EW-1:0] b_entry;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_cnt      <= '0;
      first_of_line <= 1'b1;
      b_vld         <= 1'b0;
    end else begin
      b_vld <= beat_wr;
      if (beat_wr) begin
        first_of_line <= beat_last;
        if (beat_last)
          line_cnt <= (line_cnt == LW'(FRAME_LINES - 1)) ? '0 : line_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    b_entry <= {beat_user, beat_last, beat_keep, beat_data};
  end

  // ---------------- beat FIFO (FWFT) ----------------
  // Handshake: a beat transfers on any edge where m_axis_tvalid && m_axis_tready;
  // while tvalid is high and tready low the head entry and all payload stay put.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, push, drop;

  always_comb begin
    full = (count == (AW + 1)'(FIFO_DEPTH));
    pop  = m_axis_tvalid && m_axis_tready;
    push = b_vld && (!full || pop);
    drop = b_vld && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= b_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop)           overflow_o <= 1'b1;
      else if (clr_ovf_i) overflow_o <= 1'b0;
    end
  end

  assign m_axis_tvalid = (count != '0);
  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem[rd_ptr];
  assign fill_o = count;

endmodule

// File: tb/tb_rel_phase_mask_pack.sv
// Self-checking bench for rel_phase_mask_pack: a bench-side packer model fills a
// scoreboard queue, and a monitor compares every accepted output beat against it.
module tb_rel_phase_mask_pack;

  localparam int FL = 2;
  localparam int EW = 38;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vld_i, tlast_i, clr_ovf_i;
  logic [15:0] phase_i, mod_i, mod_thresh_i;
  logic        m_axis_tvalid, m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast, m_axis_tuser, overflow_o;
  logic [6:0]  fill_o;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  // bench model of the packer
  logic        m_half;
  logic [15:0] m_low;
  int          m_line;
  logic        m_first;

  rel_phase_mask_pack #(.DATA_WIDTH(16), .FIFO_DEPTH(64), .FRAME_LINES(FL),
                        .INVALID_CODE(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .phase_i(phase_i), .mod_i(mod_i),
    .tlast_i(tlast_i), .mod_thresh_i(mod_thresh_i), .clr_ovf_i(clr_ovf_i),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .overflow_o(overflow_o), .fill_o(fill_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_half = 1'b0; m_line = 0; m_first = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_px(input logic [15:0] ph, input logic [15:0] md, input logic last);
    logic [15:0] lane;
    logic [EW-1:0] e;
`ifdef REL_PHASE_OFFSET_EN
    lane = (md >= mod_thresh_i) ? ph + 16'd25736 : 16'h8000;
`else
    lane = (md >= mod_thresh_i) ? ph : 16'h8000;
`endif
    vld_i = 1'b1; phase_i = ph; mod_i = md; tlast_i = last;
    @(posedge clk); #1;
    vld_i = 1'b0; tlast_i = 1'b0;
    if (!m_half && !last) begin
      m_half = 1'b1;
      m_low  = lane;
    end else begin
      if (m_half) e = {(m_first && m_line == 0), last, 4'hF, lane, m_low};
      else        e = {(m_first && m_line == 0), 1'b1, 4'h3, 16'h0000, lane};
      exp_q.push_back(e);
      m_half  = 1'b0;
      m_first = last;
      if (last) m_line = (m_line == FL - 1) ? 0 : m_line + 1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      logic [EW-1:0] got, want;
      got = {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got %h, required none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL beat: got user=%b last=%b keep=%h data=%h, required user=%b last=%b keep=%h data=%h",
                   got[37], got[36], got[35:32], got[31:0], want[37], want[36], want[35:32], want[31:0]);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || overflow_o !== 1'b0 || fill_o !== 7'd0) begin
      errors++;
      $display("FAIL reset: got tvalid=%b ovf=%b fill=%0d, required 0 0 0", m_axis_tvalid, overflow_o, fill_o);
    end
  endtask

  task automatic test_basic_line();
    m_axis_tready = 1'b1; mod_thresh_i = 16'd10;
    drive_px(16'h0100, 16'd20, 1'b0);
    drive_px(16'h0200, 16'd20, 1'b0);
    drive_px(16'h0300, 16'd20, 1'b0);
    drive_px(16'h0400, 16'd20, 1'b1);
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_latency();
    int n;
    // beat-completing pixel sampled at edge N must be visible right after edge N+2
    m_axis_tready = 1'b0;
    drive_px(16'h0055, 16'd20, 1'b1);
    n = 0;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL latency_early: got tvalid=%b at N, required 0", m_axis_tvalid); end
    @(posedge clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL latency_early: got tvalid=%b at N+1, required 0", m_axis_tvalid); end
    @(posedge clk); #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || fill_o !== 7'd1) begin
      errors++; $display("FAIL latency: got tvalid=%b fill=%0d at N+2, required 1 1", m_axis_tvalid, fill_o);
    end
    m_axis_tready = 1'b1;
    wait_drain(50);
  endtask

  task automatic test_odd_line();
    m_axis_tready = 1'b1;
    drive_px(16'h0011, 16'd20, 1'b0);
    drive_px(16'h0022, 16'd20, 1'b0);
    drive_px(16'h0033, 16'd20, 1'b1);
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL odd_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_mask_boundary();
    m_axis_tready = 1'b1; mod_thresh_i = 16'd10;
    drive_px(16'h1234, 16'd9, 1'b0);
    drive_px(16'h0000, 16'd10, 1'b0);
    drive_px(16'h7FFF, 16'hFFFF, 1'b0);
    drive_px(16'hCDEF, 16'd0, 1'b1);
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mask_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 128; i++) drive_px(16'(i * 3 + 1), 16'd50, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fill_o !== 7'd64 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_full64: got fill=%0d ovf=%b, required 64 0", fill_o, overflow_o);
    end
    drive_px(16'hAAAA, 16'd50, 1'b0);
    drive_px(16'hBBBB, 16'd50, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    checks++;
    if (fill_o !== 7'd64 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_full65: got fill=%0d ovf=%b, required 64 1", fill_o, overflow_o);
    end
    m_axis_tready = 1'b1;
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0 || fill_o !== 7'd0) begin
      errors++; $display("FAIL ovf_drain: got left=%0d fill=%0d, required 0 0", exp_q.size(), fill_o);
    end
    checks++;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow_o); end
    clr_ovf_i = 1'b1;
    @(posedge clk); #1;
    clr_ovf_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow_o); end
    // close the line so later tests start on a fresh line
    drive_px(16'h0001, 16'd50, 1'b1);
    wait_drain(50);
  endtask

  task automatic test_frame_markers();
    do_reset();
    m_axis_tready = 1'b1;
    for (int l = 0; l < 3; l++) begin
      drive_px(16'(16'h0100 + l), 16'd50, 1'b0);
      drive_px(16'(16'h0200 + l), 16'd50, 1'b1);
    end
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL frame_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int len;
    mod_thresh_i = 16'd100;
    for (int l = 0; l < 6; l++) begin
      len = $urandom_range(1, 7);
      for (int p = 0; p < len; p++) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        drive_px(16'($urandom_range(0, 65535)), 16'($urandom_range(80, 120)), p == len - 1);
      end
    end
    m_axis_tready = 1'b1;
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_line();
    mod_thresh_i = 16'd10;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) drive_px(16'(16'h0A00 + i), 16'd20, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fill_o !== 7'd2) begin errors++; $display("FAIL rml_fill: got %0d, required 2", fill_o); end
    do_reset();
    checks++;
    if (m_axis_tvalid !== 1'b0 || fill_o !== 7'd0) begin
      errors++; $display("FAIL rml_flush: got tvalid=%b fill=%0d, required 0 0", m_axis_tvalid, fill_o);
    end
    m_axis_tready = 1'b1;
    drive_px(16'h0B01, 16'd20, 1'b0);
    drive_px(16'h0B02, 16'd20, 1'b1);
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rml_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; vld_i = 1'b0; tlast_i = 1'b0; clr_ovf_i = 1'b0;
    phase_i = '0; mod_i = '0; mod_thresh_i = 16'd10; m_axis_tready = 1'b0;
    m_half = 1'b0; m_low = '0; m_line = 0; m_first = 1'b1;
    test_reset();
    test_basic_line();
    test_odd_line();
    test_latency();
    test_mask_boundary();
    test_overflow();
    test_frame_markers();
    test_back_to_back();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
